// File: rtl/shift_pkg.sv
// Shared encodings for the parametrised shift register: manual operation
// codes and burst FSM states.
package shift_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD  = 3'b000,
        MODE_SHL   = 3'b001,
        MODE_SHR   = 3'b010,
        MODE_LOAD  = 3'b011,
        MODE_ROL   = 3'b100,
        MODE_ROR   = 3'b101,
        MODE_ASR   = 3'b110,
        MODE_HOLD2 = 3'b111
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_bit_counter.sv
// Burst bit counter: cleared at burst start, counts enabled shifts, flags the
// last bit (count == WIDTH-1) so the FSM can leave SHIFT on that shift.
module shift_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic last
);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && (count_reg != CW'(WIDTH))) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign last = (count_reg == CW'(WIDTH - 1));

endmodule

// File: rtl/param_shift_reg.sv
// Parametrised shift register with manual operations in IDLE and a
// start-triggered serialising burst (IDLE -> SHIFT -> DONE).
module param_shift_reg
    import shift_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             si,
    input  logic [WIDTH-1:0] pi,
    input  logic             start,
    output logic [WIDTH-1:0] po,
    output logic             so,
    output logic             busy,
    output logic             done
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] po_reg, po_next;
    logic             busy_reg, done_reg;
    logic             cnt_clear, cnt_inc, cnt_last;

    shift_bit_counter #(.WIDTH(WIDTH)) u_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .last  (cnt_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            po_reg    <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            po_reg    <= po_next;
            busy_reg  <= (state_next == ST_SHIFT);
            done_reg  <= (state_next == ST_DONE);
        end
    end

    always_comb begin
        state_next = state_reg;
        po_next    = po_reg;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                // start wins over any manual operation and ignores en
                if (start) begin
                    po_next    = pi;
                    cnt_clear  = 1'b1;
                    state_next = ST_SHIFT;
                end else if (en) begin
                    case (mode_t'(mode))
                        MODE_SHL:  po_next = {po_reg[WIDTH-2:0], si};
                        MODE_SHR:  po_next = {si, po_reg[WIDTH-1:1]};
                        MODE_LOAD: po_next = pi;
                        MODE_ROL:  po_next = {po_reg[WIDTH-2:0], po_reg[WIDTH-1]};
                        MODE_ROR:  po_next = {po_reg[0], po_reg[WIDTH-1:1]};
                        MODE_ASR:  po_next = {po_reg[WIDTH-1], po_reg[WIDTH-1:1]};
                        default:   po_next = po_reg;
                    endcase
                end
            end
            ST_SHIFT: begin
                if (en) begin
                    po_next = (MSB_FIRST != 0) ? {po_reg[WIDTH-2:0], si}
                                               : {si, po_reg[WIDTH-1:1]};
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        so = po_reg[0];
        if (state_reg == ST_IDLE) begin
            if ((mode_t'(mode) == MODE_SHL) || (mode_t'(mode) == MODE_ROL)) begin
                so = po_reg[WIDTH-1];
            end
        end else if (MSB_FIRST != 0) begin
            so = po_reg[WIDTH-1];
        end
    end

    assign po   = po_reg;
    assign busy = busy_reg;
    assign done = done_reg;

endmodule

// File: tb/tb_param_shift_reg.sv
// Bench for param_shift_reg: manual operations on an MSB-first instance and
// scoreboarded serial bursts on both MSB-first and LSB-first instances.
module tb_param_shift_reg;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic       si;
    logic [7:0] pi;
    logic       start;

    logic [7:0] po_m, po_l;
    logic       so_m, so_l, busy_m, busy_l, done_m, done_l;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    param_shift_reg #(.WIDTH(8), .MSB_FIRST(1)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .si(si), .pi(pi),
        .start(start), .po(po_m), .so(so_m), .busy(busy_m), .done(done_m)
    );

    param_shift_reg #(.WIDTH(8), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .si(si), .pi(pi),
        .start(start), .po(po_l), .so(so_l), .busy(busy_l), .done(done_l)
    );

    // One manual operation: en high for exactly one rising edge.
    task automatic apply_mode(input logic [2:0] m, input logic [7:0] p, input logic s);
        @(negedge clk);
        en = 1'b1; mode = m; pi = p; si = s;
        @(negedge clk);
        en = 1'b0; mode = 3'b000; si = 1'b0;
        $display("op mode=%b pi=%h si=%b -> po=%h", m, p, s, po_m);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; mode = 3'b000; si = 1'b0; pi = 8'h00; start = 1'b0;
        #12;
        checks++;
        if (po_m !== 8'h00 || busy_m !== 1'b0 || done_m !== 1'b0 || so_m !== 1'b0) begin
            errors++;
            $display("FAIL reset: po=%h busy=%b done=%b so=%b, want 00 0 0 0", po_m, busy_m, done_m, so_m);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if (po_m !== 8'h00 || busy_m !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: po=%h busy=%b, want 00 0", po_m, busy_m);
        end
        $display("reset: po=%h busy=%b done=%b", po_m, busy_m, done_m);
    endtask

    task automatic test_load_rotate();
        apply_mode(3'b011, 8'hA5, 1'b0);
        checks++;
        if (po_m !== 8'hA5) begin errors++; $display("FAIL load: po=%h want a5", po_m); end
        apply_mode(3'b100, 8'h00, 1'b0);
        checks++;
        if (po_m !== 8'h4B) begin errors++; $display("FAIL rotl: po=%h want 4b", po_m); end
        apply_mode(3'b011, 8'hA5, 1'b0);
        apply_mode(3'b101, 8'h00, 1'b0);
        checks++;
        if (po_m !== 8'hD2) begin errors++; $display("FAIL rotr: po=%h want d2", po_m); end
    endtask

    task automatic test_asr_hold();
        apply_mode(3'b011, 8'h90, 1'b0);
        apply_mode(3'b110, 8'h00, 1'b0);
        checks++;
        if (po_m !== 8'hC8) begin errors++; $display("FAIL asr: po=%h want c8", po_m); end
        mode = 3'b110; pi = 8'hFF; si = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (po_m !== 8'hC8) begin errors++; $display("FAIL en0_hold[%0d]: po=%h want c8", i, po_m); end
            $display("hold cycle %0d: po=%h", i, po_m);
        end
        mode = 3'b000; si = 1'b0;
    endtask

    task automatic test_shift_so_select();
        apply_mode(3'b011, 8'hA5, 1'b0);
        apply_mode(3'b001, 8'h00, 1'b1);
        checks++;
        if (po_m !== 8'h4B) begin errors++; $display("FAIL shl_si1: po=%h want 4b", po_m); end
        apply_mode(3'b010, 8'h00, 1'b0);
        checks++;
        if (po_m !== 8'h25) begin errors++; $display("FAIL shr_si0: po=%h want 25", po_m); end
        apply_mode(3'b111, 8'hFF, 1'b1);
        checks++;
        if (po_m !== 8'h25) begin errors++; $display("FAIL mode111_hold: po=%h want 25", po_m); end
        // po=00100101: MSB is 0, LSB is 1
        mode = 3'b100; #1;
        checks++;
        if (so_m !== 1'b0) begin errors++; $display("FAIL so_rol_msb: so=%b want 0", so_m); end
        mode = 3'b010; #1;
        checks++;
        if (so_m !== 1'b1) begin errors++; $display("FAIL so_shr_lsb: so=%b want 1", so_m); end
        mode = 3'b000;
    endtask

    // Bits are pushed on start and popped each enabled SHIFT cycle.
    task automatic test_burst(input logic [7:0] data, input bit lsb, input bit stall,
                              input bit inject_start);
        int  busy_cycles = 0;
        int  popped      = 0;
        int  stall_cnt   = 0;
        bit  finished    = 0;
        logic so_s, busy_s, done_s;
        logic [7:0] po_s;
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(lsb ? data[i] : data[7-i]);
        @(negedge clk);
        pi = data; si = 1'b0; en = 1'b1; start = 1'b1; mode = 3'b011;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 40 && !finished; cyc++) begin
            so_s   = lsb ? so_l : so_m;
            busy_s = lsb ? busy_l : busy_m;
            done_s = lsb ? done_l : done_m;
            po_s   = lsb ? po_l : po_m;
            start  = 1'b0;
            if (busy_s === 1'b1) begin
                busy_cycles++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL burst_extra_bit: so=%b, want no more busy cycles", so_s);
                end else if (so_s !== exp_q[0]) begin
                    errors++; $display("FAIL burst_bit%0d: so=%b want %b", popped, so_s, exp_q[0]);
                end
                $display("burst cyc %0d: so=%b busy=%b", busy_cycles, so_s, busy_s);
                if (stall && popped == 3 && stall_cnt < 2) begin
                    en = 1'b0; stall_cnt++;
                end else begin
                    en = 1'b1;
                    if (exp_q.size() != 0) void'(exp_q.pop_front());
                    popped++;
                end
                if (inject_start && popped == 5) begin
                    start = 1'b1; pi = 8'hFF;
                end
                @(negedge clk);
            end else begin
                finished = 1;
                checks++;
                if (done_s !== 1'b1 || po_s !== 8'h00 || exp_q.size() != 0 ||
                    busy_cycles != (stall ? 10 : 8)) begin
                    errors++;
                    $display("FAIL burst_done: done=%b po=%h left=%0d busy_cycles=%0d, want 1 00 0 %0d",
                             done_s, po_s, exp_q.size(), busy_cycles, stall ? 10 : 8);
                end
            end
        end
        if (!finished) begin
            errors++; $display("FAIL burst_timeout: busy still high after 40 cycles");
        end
        start = 1'b0; en = 1'b0; mode = 3'b000;
        @(negedge clk);
        checks++;
        if ((lsb ? done_l : done_m) !== 1'b0 || (lsb ? busy_l : busy_m) !== 1'b0) begin
            errors++; $display("FAIL burst_idle_after: done=%b busy=%b want 0 0",
                               lsb ? done_l : done_m, lsb ? busy_l : busy_m);
        end
        $display("burst data=%h lsb=%0d stall=%0d: %0d busy cycles", data, lsb, stall, busy_cycles);
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        pi = 8'hC3; si = 1'b0; en = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy_m !== 1'b1) begin errors++; $display("FAIL midburst_busy: busy=%b want 1", busy_m); end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (po_m !== 8'h00 || busy_m !== 1'b0 || done_m !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: po=%h busy=%b done=%b want 00 0 0", po_m, busy_m, done_m);
        end
        $display("reset mid-burst: po=%h busy=%b done=%b", po_m, busy_m, done_m);
        @(negedge clk); rst = 1'b0; en = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (po_m !== 8'h00 || busy_m !== 1'b0 || done_m !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_idle: po=%h busy=%b done=%b want 00 0 0", po_m, busy_m, done_m);
        end
    endtask

    initial begin
        test_reset();
        test_load_rotate();
        test_asr_hold();
        test_shift_so_select();
        test_burst(8'hC3, 1'b0, 1'b0, 1'b0);
        test_burst(8'hC3, 1'b0, 1'b1, 1'b1);
        test_burst(8'hC3, 1'b1, 1'b0, 1'b0);
        test_burst(8'h2D, 1'b1, 1'b1, 1'b0);
        test_burst(8'h9A, 1'b0, 1'b0, 1'b0);
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
